// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipe W stage first, MCycle/FPU results via 1-entry buffers, round-robin.
// Latency: pipe writes same cycle; a unit result is written at the earliest the cycle after its handshake.
// Backpressure: X_Ready drops while X's buffer is occupied and not draining; starvation forces StallWB.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 PipeWE,
    input  logic [ADDR_W-1:0]    PipeWA,
    input  logic [DATA_W-1:0]    PipeWD,
    input  logic                 MC_Valid,
    output logic                 MC_Ready,
    input  logic [ADDR_W-1:0]    MC_WA,
    input  logic [DATA_W-1:0]    MC_WD,
    input  logic                 FP_Valid,
    output logic                 FP_Ready,
    input  logic [ADDR_W-1:0]    FP_WA,
    input  logic [DATA_W-1:0]    FP_WD,
    output logic                 RF_WE,
    output logic [ADDR_W-1:0]    RF_WA,
    output logic [DATA_W-1:0]    RF_WD,
    output logic [1:0]           GrantSrc,
    output logic                 StallWB,
    output logic [2**ADDR_W-1:0] PendMask
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic              mc_v, fp_v;
    logic [ADDR_W-1:0] mc_wa, fp_wa;
    logic [DATA_W-1:0] mc_wd, fp_wd;
    logic              rr_ptr;
    logic [CW-1:0]     starve_cnt;

    logic pipe_g, mc_g, fp_g, stall;

    // Everything is gated by RESETn so the port stays quiet while reset is held low.
    always_comb begin
        stall   = RESETn & (starve_cnt == CNT_MAX);
        pipe_g  = RESETn & PipeWE & ~stall;
        mc_g    = RESETn & ~pipe_g & mc_v & (~fp_v | ~rr_ptr);
        fp_g    = RESETn & ~pipe_g & fp_v & (~mc_v | rr_ptr);
        StallWB = stall;
        MC_Ready = RESETn & (~mc_v | mc_g);
        FP_Ready = RESETn & (~fp_v | fp_g);

        RF_WE    = 1'b0;
        RF_WA    = '0;
        RF_WD    = '0;
        GrantSrc = 2'b00;
        if (pipe_g) begin
            RF_WE    = 1'b1;
            RF_WA    = PipeWA;
            RF_WD    = PipeWD;
            GrantSrc = 2'b01;
        end else if (mc_g) begin
            RF_WE    = 1'b1;
            RF_WA    = mc_wa;
            RF_WD    = mc_wd;
            GrantSrc = 2'b10;
        end else if (fp_g) begin
            RF_WE    = 1'b1;
            RF_WA    = fp_wa;
            RF_WD    = fp_wd;
            GrantSrc = 2'b11;
        end
    end

    always_comb begin
        PendMask = '0;
        if (mc_v) PendMask[mc_wa] = 1'b1;
        if (fp_v) PendMask[fp_wa] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            mc_v       <= 1'b0;
            mc_wa      <= '0;
            mc_wd      <= '0;
            fp_v       <= 1'b0;
            fp_wa      <= '0;
            fp_wd      <= '0;
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            // A granted buffer always hands priority to the other one, which covers
            // both the alternating and the single-valid cases.
            if (mc_g)      rr_ptr <= 1'b1;
            else if (fp_g) rr_ptr <= 1'b0;

            if (mc_g || fp_g || !(mc_v || fp_v))
                starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;

            if (MC_Valid && MC_Ready) begin
                mc_v  <= 1'b1;
                mc_wa <= MC_WA;
                mc_wd <= MC_WD;
            end else if (mc_g) begin
                mc_v  <= 1'b0;
            end

            if (FP_Valid && FP_Ready) begin
                fp_v  <= 1'b1;
                fp_wa <= FP_WA;
                fp_wd <= FP_WD;
            end else if (fp_g) begin
                fp_v  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue-style model.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          pipe_we = 1'b0;
    logic [AW-1:0] pipe_wa = '0;
    logic [DW-1:0] pipe_wd = '0;
    logic          mc_valid = 1'b0, fp_valid = 1'b0;
    logic          mc_ready, fp_ready;
    logic [AW-1:0] mc_wa = '0, fp_wa = '0;
    logic [DW-1:0] mc_wd = '0, fp_wd = '0;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [1:0]    grant;
    logic          stall;
    logic [15:0]   pend;

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .CLK(clk), .RESETn(rstn),
        .PipeWE(pipe_we), .PipeWA(pipe_wa), .PipeWD(pipe_wd),
        .MC_Valid(mc_valid), .MC_Ready(mc_ready), .MC_WA(mc_wa), .MC_WD(mc_wd),
        .FP_Valid(fp_valid), .FP_Ready(fp_ready), .FP_WA(fp_wa), .FP_WD(fp_wd),
        .RF_WE(rf_we), .RF_WA(rf_wa), .RF_WD(rf_wd),
        .GrantSrc(grant), .StallWB(stall), .PendMask(pend)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: index 0 = MCycle buffer, 1 = FPU buffer.
    bit            m_v[2];
    bit [AW-1:0]   m_wa[2];
    bit [DW-1:0]   m_wd[2];
    int            m_pref;     // buffer that wins a tie
    int            m_denied;   // consecutive cycles a valid buffer went unserved
    bit            e_rdy[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 0; m_wa[i] = '0; m_wd[i] = '0;
        end
        m_pref = 0;
        m_denied = 0;
    endtask

    // Drive one cycle's inputs at the negedge, compare against the model, advance the model.
    task automatic step(input bit pwe, input bit [AW-1:0] pwa, input bit [DW-1:0] pwd,
                        input bit mv, input bit [AW-1:0] mwa, input bit [DW-1:0] mwd,
                        input bit fv, input bit [AW-1:0] fwa, input bit [DW-1:0] fwd);
        int g;
        bit e_stall, e_we;
        bit [AW-1:0] e_wa;
        bit [DW-1:0] e_wd;
        bit [1:0] e_src;
        bit [15:0] e_pend;
        bit in_v[2];
        bit [AW-1:0] in_wa[2];
        bit [DW-1:0] in_wd[2];
        pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
        mc_valid = mv; mc_wa = mwa; mc_wd = mwd;
        fp_valid = fv; fp_wa = fwa; fp_wd = fwd;
        in_v[0] = mv; in_wa[0] = mwa; in_wd[0] = mwd;
        in_v[1] = fv; in_wa[1] = fwa; in_wd[1] = fwd;
        #1;
        e_stall = (m_denied == SMAX);
        g = -1;
        e_we = 0; e_wa = '0; e_wd = '0; e_src = 2'b00;
        if (pwe && !e_stall) begin
            e_we = 1; e_wa = pwa; e_wd = pwd; e_src = 2'b01;
        end else begin
            if (m_v[0] && m_v[1]) g = m_pref;
            else if (m_v[0]) g = 0;
            else if (m_v[1]) g = 1;
            if (g >= 0) begin
                e_we = 1; e_wa = m_wa[g]; e_wd = m_wd[g]; e_src = (g == 0) ? 2'b10 : 2'b11;
            end
        end
        e_pend = '0;
        for (int i = 0; i < 2; i++) begin
            if (m_v[i]) e_pend[m_wa[i]] = 1'b1;
            e_rdy[i] = !m_v[i] || (g == i);
        end
        chk("rf_we", rf_we, e_we);
        chk("rf_wa", rf_wa, e_wa);
        chk("rf_wd", rf_wd, e_wd);
        chk("grant", grant, e_src);
        chk("stall", stall, e_stall);
        chk("pend", pend, e_pend);
        chk("mc_ready", mc_ready, e_rdy[0]);
        chk("fp_ready", fp_ready, e_rdy[1]);
        if (g >= 0) m_pref = 1 - g;
        if (g >= 0 || !(m_v[0] || m_v[1])) m_denied = 0;
        else if (m_denied < SMAX) m_denied++;
        for (int i = 0; i < 2; i++) begin
            if (g == i) m_v[i] = 0;
            if (in_v[i] && e_rdy[i]) begin
                m_v[i] = 1; m_wa[i] = in_wa[i]; m_wd[i] = in_wd[i];
            end
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, '0, '0, 0, '0, '0, 0, '0, '0);
    endtask

    // Enter reset at a negedge with the pipe requesting; outputs must go quiet at once.
    task automatic do_reset();
        pipe_we = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_pend", pend, 16'h0);
        chk("rst_mc_ready", mc_ready, 1'b0);
        chk("rst_fp_ready", fp_ready, 1'b0);
        chk("rst_stall", stall, 1'b0);
        model_clear();
        pipe_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int found;
        bit mv, fv, pwe;
        bit [AW-1:0] mwa, fwa;
        bit [DW-1:0] mwd, fwd;

        model_clear();
        @(negedge clk);
        do_reset();

        // Single MC result: written next cycle, pending mask set for that cycle only.
        step(0, '0, '0, 1, 4'd3, 32'h1234, 0, '0, '0);
        chk("t1_ready", mc_ready, 1'b1);
        adv(); idle();
        chk("t1_we", rf_we, 1'b1);
        chk("t1_wa", rf_wa, 4'd3);
        chk("t1_wd", rf_wd, 32'h1234);
        chk("t1_src", grant, 2'b10);
        chk("t1_pend", pend, 16'h0008);
        adv(); idle();
        chk("t1_pend_clr", pend, 16'h0);
        adv();

        // Simultaneous MC/FP: R1 then R2, and R1 first again on repeat.
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            step(0, '0, '0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2);
            adv(); idle();
            chk("t2_first_wa", rf_wa, 4'd1);
            chk("t2_first_src", grant, 2'b10);
            adv(); idle();
            chk("t2_second_wa", rf_wa, 4'd2);
            chk("t2_second_src", grant, 2'b11);
            adv();
        end

        // Streaming MC results back to back.
        do_reset();
        step(0, '0, '0, 1, 4'd7, 32'hA, 0, '0, '0);
        chk("t4_rdy_a", mc_ready, 1'b1);
        adv();
        step(0, '0, '0, 1, 4'd7, 32'hB, 0, '0, '0);
        chk("t4_rdy_b", mc_ready, 1'b1);
        chk("t4_wd_a", rf_wd, 32'hA);
        adv();
        step(0, '0, '0, 1, 4'd7, 32'hC, 0, '0, '0);
        chk("t4_rdy_c", mc_ready, 1'b1);
        chk("t4_wd_b", rf_wd, 32'hB);
        adv(); idle();
        chk("t4_wd_c", rf_wd, 32'hC);
        adv();

        // Starvation under a busy pipe, with a second MC result waiting.
        do_reset();
        step(1, 4'd9, 32'h99, 1, 4'd6, 32'h11, 0, '0, '0);
        adv();
        found = -1;
        for (int c = 0; c < 10 && found < 0; c++) begin
            step(1, 4'd9, 32'h99, 1, 4'd6, 32'h22, 0, '0, '0);
            if (stall) begin
                found = c;
                chk("t3_src", grant, 2'b10);
                chk("t3_wd", rf_wd, 32'h11);
                chk("t5_ready_at_grant", mc_ready, 1'b1);
            end else begin
                chk("t5_ready_blocked", mc_ready, 1'b0);
            end
            adv();
        end
        chk("t3_denied_before_stall", found, SMAX);
        step(1, 4'd9, 32'h99, 0, '0, '0, 0, '0, '0);
        chk("t3_stall_off", stall, 1'b0);
        chk("t3_pipe_src", grant, 2'b01);
        chk("t5_new_pending", pend, 16'h0040);
        adv(); idle();
        chk("t5_new_wd", rf_wd, 32'h22);
        adv();

        // Reset while an R5 write waits: dropped, never written afterwards.
        do_reset();
        step(0, '0, '0, 1, 4'd5, 32'h55, 0, '0, '0);
        adv();
        step(1, 4'd0, 32'h0, 0, '0, '0, 0, '0, '0);
        adv();
        chk("t6_pend_before", pend, 16'h0020);
        do_reset();
        for (int c = 0; c < 6; c++) begin
            idle();
            chk("t6_no_write", rf_we, 1'b0);
            adv();
        end

        // Randomized traffic; units hold their payload until accepted.
        mv = 0; fv = 0; mwa = '0; fwa = '0; mwd = '0; fwd = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!mv && $urandom_range(0, 2) == 0) begin
                mv = 1; mwa = AW'($urandom); mwd = $urandom;
            end
            if (!fv && $urandom_range(0, 2) == 0) begin
                fv = 1; fwa = AW'($urandom); fwd = $urandom;
            end
            pwe = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 85 : 40));
            step(pwe, AW'($urandom), $urandom, mv, mwa, mwd, fv, fwa, fwd);
            if (mv && e_rdy[0]) mv = 0;
            if (fv && e_rdy[1]) fv = 0;
            adv();
            if (c == 1700) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
